bcd_serial_sub_ctrl: RTL
========================

Name: bcd_serial_sub_ctrl

Overview:
Sequencer for a multi-digit BCD subtraction, computing A - B in sign-magnitude BCD.
- Time-shares one single-digit borrow-chained BCD digit subtractor across DIGITS digits, least-significant digit (LSD) first, one digit per cycle.
- If pass 1 ends in a borrow, runs a second ten's-complement pass on the same digit unit to produce the magnitude.
- Sits between the operand source (valid/ready) and the result consumer (valid/ready) in the BCD arithmetic datapath.

Parameters:
DIGITS, 4, number of BCD digits per operand; must be >= 1.
CNT_W, $clog2(DIGITS+1), width of the digit index counter.

Ports:
clk  in  1  rising-edge clock; single clock domain.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operands a/b valid.
in_ready  out  1  controller can accept operands; high only in IDLE.
a  in  4*DIGITS  minuend; digit i is a[4i+3:4i]; digit 0 is the LSD.
b  in  4*DIGITS  subtrahend; same packing as a.
out_valid  out  1  result valid; held until accepted.
out_ready  in  1  consumer accepts the result.
diff  out  4*DIGITS  BCD magnitude of |a-b|.
sign  out  1  1 = negative (a<b); 0 for zero or positive results.
err  out  1  invalid BCD input digit; see Optional Feature.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - state returns to IDLE; aborts any operation in progress, including mid-pass or mid-DONE.
  - in_ready=1 in the cycle after reset; out_valid=0, diff=0, sign=0, err=0; counter, borrow and shift registers cleared.
- Digit unit function: d = x - y - bin.
  - If x >= y+bin: d = x-y-bin, bout=0.
  - Otherwise: d = x+10-y-bin, bout=1.
  - All arithmetic is done on 5-bit intermediates.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a into SA and b into SB (shift registers), clear borrow and counter, go to SUB.
  - SUB, pass 1: x=SA digit 0, y=SB digit 0, bin=borrow.
    - Shift SA/SB right one digit; shift d into the top of the result register R; borrow<=bout; cnt++.
    - After DIGITS cycles: if borrow=1, set sign<=1, clear borrow and counter, go to NEG; otherwise sign<=0, go to DONE.
  - NEG, pass 2: x=0, y=R digit 0, bin=borrow.
    - Shift R right and shift d into the top of R; borrow<=bout.
    - After DIGITS cycles, go to DONE. R now holds 10^DIGITS - raw, which is the magnitude.
  - DONE: out_valid=1; diff=R, sign and err stable. On out_ready, go to IDLE. out_valid stays high while out_ready is low.
- Latency, with operands accepted at cycle T:
  - out_valid asserts at T+1+DIGITS for non-negative results.
  - out_valid asserts at T+1+2*DIGITS for negative results.
  - Minimum one idle cycle between results; in_ready is never high in DONE.
- Result register:
  - diff/sign/err are driven only from R, the sign register and the err register.
  - They hold their last result after acceptance until the next DONE.
- Raw result 0: borrow=0, so sign=0 and there is no negative zero.
- a/b are ignored outside the accept cycle.

Optional Feature:
Macro: BCD_SUB_CHECK_EN.
- Defined: at accept, any digit of a or b greater than 9 sets err<=1. The controller then skips SUB/NEG and enters DONE the next cycle (out_valid at T+1) with diff=0, sign=0. err clears at the next accept.
- Undefined: no check; err tied to 0. Non-BCD digits give an unspecified diff, but the state sequence and latency are unchanged.

Decomposition:
- Package bcd_sub_pkg:
  - DIGIT_W=4, BCD_MAX=4'd9, BCD_RADIX=5'd10;
  - state enum {IDLE, SUB, NEG, DONE};
  - function is_bcd_digit.
- Sub-module bcd_digit_sub: combinational x[3:0], y[3:0], bin -> d[3:0], bout. It is instantiated once and its inputs are muxed by state.

Test Plan (DIGITS=4):
- a=5432, b=1234 -> diff=4198, sign=0, out_valid at T+5.
- a=1234, b=5432 -> pass-1 raw R=5802 with borrow; final diff=4198, sign=1, out_valid at T+9.
- a=0000, b=0001 -> raw R=9999; final diff=0001, sign=1. a=0500, b=0500 -> diff=0000, sign=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid, diff and sign stable; in_ready=0 throughout; in_ready returns to 1 the cycle after the handshake.
- Assert rst during NEG -> next cycle IDLE, out_valid=0, in_ready=1, diff=0. A fresh operation after reset completes correctly.
- BCD_SUB_CHECK_EN defined, a=00A0 -> err=1, diff=0, sign=0, out_valid at T+1. Undefined: err stays 0.

Source files
------------

// File: rtl/bcd_sub_pkg.sv
// Shared definitions for the serial BCD subtractor: digit geometry, FSM states, digit validity helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package bcd_sub_pkg;

  localparam int         DIGIT_W   = 4;
  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [4:0] BCD_RADIX = 5'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic is_bcd_digit(input logic [DIGIT_W-1:0] dig);
    return (dig <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single-digit BCD subtractor with borrow chain: d = x - y - bin, wrapped into 0..9 with bout on underflow.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: x, y  BCD digits; bin  borrow in; d  BCD difference digit; bout  borrow out.
module bcd_digit_sub
  import bcd_sub_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout
);

  logic [4:0] xe;
  logic [4:0] ye;
  logic [4:0] res;

  always_comb begin
    xe = {1'b0, x};
    ye = {1'b0, y} + {4'd0, bin};
    if (xe >= ye) begin
      res  = xe - ye;
      bout = 1'b0;
    end else begin
      // Borrow a ten from the next digit up.
      res  = xe + BCD_RADIX - ye;
      bout = 1'b1;
    end
    d = res[DIGIT_W-1:0];
  end

endmodule

// File: rtl/bcd_serial_sub_ctrl.sv
// Sign-magnitude BCD subtractor |a-b|, one digit per cycle LSD first; a second ten's-complement pass fixes negatives.
// Latency: out_valid DIGITS+1 cycles after accept (2*DIGITS+1 if negative; 1 on bad digit with BCD_SUB_CHECK_EN).
// Backpressure: in_ready only in IDLE; result held with out_valid high until out_ready.
// Ports: clk/rst (sync, active high); in_valid/in_ready/a/b operand side; out_valid/out_ready/diff/sign/err result side.
// Optional macro BCD_SUB_CHECK_EN: flag non-BCD input digits on err and return a zero result immediately.
module bcd_serial_sub_ctrl
  import bcd_sub_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] diff,
  output logic                      sign,
  output logic                      err
);

  localparam int W = DIGIT_W * DIGITS;

  state_t             state;
  logic [W-1:0]       sa;
  logic [W-1:0]       sb;
  logic [W-1:0]       r;
  logic [W-1:0]       diff_q;
  logic               sign_q;
  logic               borrow;
  logic [CNT_W-1:0]   cnt;

  logic [DIGIT_W-1:0] du_x;
  logic [DIGIT_W-1:0] du_y;
  logic               du_bin;
  logic [DIGIT_W-1:0] du_d;
  logic               du_bout;
  logic [W-1:0]       r_in;
  logic               last;

  // The one shared digit unit; operands come from SA/SB in pass 1 and from R in pass 2.
  always_comb begin
    du_x   = '0;
    du_y   = '0;
    du_bin = 1'b0;
    case (state)
      SUB: begin
        du_x   = sa[DIGIT_W-1:0];
        du_y   = sb[DIGIT_W-1:0];
        du_bin = borrow;
      end
      NEG: begin
        du_x   = '0;
        du_y   = r[DIGIT_W-1:0];
        du_bin = borrow;
      end
      default: ;
    endcase
  end

  bcd_digit_sub u_digit (
    .x    (du_x),
    .y    (du_y),
    .bin  (du_bin),
    .d    (du_d),
    .bout (du_bout)
  );

  // R shifts right one digit and takes the new digit at the top, so after DIGITS
  // steps the LSD produced first has reached digit 0. Shift form also covers DIGITS=1.
  assign r_in = (r >> DIGIT_W) | (W'(du_d) << (DIGIT_W * (DIGITS - 1)));
  assign last = (cnt == CNT_W'(DIGITS - 1));

`ifdef BCD_SUB_CHECK_EN
  logic err_q;
  logic bad_in;

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!is_bcd_digit(a[i*DIGIT_W +: DIGIT_W]) || !is_bcd_digit(b[i*DIGIT_W +: DIGIT_W]))
        bad_in = 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      r      <= '0;
      diff_q <= '0;
      sign_q <= 1'b0;
      borrow <= 1'b0;
      cnt    <= '0;
`ifdef BCD_SUB_CHECK_EN
      err_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sa     <= a;
            sb     <= b;
            borrow <= 1'b0;
            cnt    <= '0;
`ifdef BCD_SUB_CHECK_EN
            err_q <= bad_in;
            if (bad_in) begin
              diff_q <= '0;
              sign_q <= 1'b0;
              state  <= DONE;
            end else begin
              state <= SUB;
            end
`else
            state <= SUB;
`endif
          end
        end

        SUB: begin
          sa     <= sa >> DIGIT_W;
          sb     <= sb >> DIGIT_W;
          r      <= r_in;
          borrow <= du_bout;
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            // A final borrow means a<b: R holds 10^DIGITS - |a-b|, so complement it.
            borrow <= 1'b0;
            cnt    <= '0;
            if (du_bout) begin
              state <= NEG;
            end else begin
              diff_q <= r_in;
              sign_q <= 1'b0;
              state  <= DONE;
            end
          end
        end

        NEG: begin
          r      <= r_in;
          borrow <= du_bout;
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            diff_q <= r_in;
            sign_q <= 1'b1;
            state  <= DONE;
          end
        end

        DONE: begin
          if (out_ready) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state register; diff/sign hold between DONE visits.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_q;
  assign sign      = sign_q;

endmodule
